touch_stroke_rasterizer: RTL and testbench

Sits between the FT6206 touch controller and the VRAM write port. It converts successive touch samples into continuous strokes by drawing Bresenham line segments between consecutive pen-down points. It also owns the full-VRAM clear, both after reset and on request. Output is exactly one VRAM pixel write per cycle while active.

---
 rtl/touch_stroke_rasterizer.sv | 204 ++++++++++++++++++++
 tb/tb_touch_stroke_rasterizer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_stroke_rasterizer.sv
// touch_stroke_rasterizer
// Turns consecutive pen-down touch samples into Bresenham line segments and
// streams one VRAM pixel write per active cycle. Also owns the full-screen
// clear after reset and on request. All VRAM outputs are registered.
module touch_stroke_rasterizer #(
  parameter int                DISPLAY_WIDTH  = 240,
  parameter int                DISPLAY_HEIGHT = 320,
  parameter int                VRAM_L         = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int                VRAM_W         = 16,
  parameter logic [VRAM_W-1:0] BACKGROUND     = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              touch_valid,
  input  logic [$clog2(DISPLAY_WIDTH)-1:0]  touch_x,
  input  logic [$clog2(DISPLAY_HEIGHT)-1:0] touch_y,
  input  logic [VRAM_W-1:0]                 draw_color,
  input  logic                              clear_req,
  output logic                              vram_wr_ena,
  output logic [$clog2(VRAM_L)-1:0]         vram_wr_addr,
  output logic [VRAM_W-1:0]                 vram_wr_data,
  output logic                              busy
);

  localparam int XW = $clog2(DISPLAY_WIDTH);
  localparam int YW = $clog2(DISPLAY_HEIGHT);
  localparam int AW = $clog2(VRAM_L);
  // Signed working width for deltas and error term; two guard bits keep
  // dx + dy and the accumulated error from wrapping.
  localparam int DW = ((XW > YW) ? XW : YW) + 2;

  localparam logic [XW:0]   X_LIM   = (XW + 1)'(DISPLAY_WIDTH);
  localparam logic [YW:0]   Y_LIM   = (YW + 1)'(DISPLAY_HEIGHT);
  localparam logic [AW-1:0] CLR_TOP = AW'(VRAM_L - 1);
  localparam logic [31:0]   WIDTH_U = DISPLAY_WIDTH;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SETUP, S_DRAW} state_t;

  state_t                  state_reg, state_next;
  logic [AW-1:0]           clr_cnt_reg, clr_cnt_next;
  logic                    pen_down_reg, pen_down_next;
  logic                    pending_clear_reg, pending_clear_next;
  // (x_reg, y_reg) is the current pixel; (x1_reg, y1_reg) the segment end,
  // which doubles as the last endpoint once the segment is finished.
  logic [XW-1:0]           x_reg, x_next, x1_reg, x1_next;
  logic [YW-1:0]           y_reg, y_next, y1_reg, y1_next;
  logic [VRAM_W-1:0]       color_reg, color_next;
  logic signed [DW-1:0]    dx_reg, dx_next, dy_reg, dy_next, err_reg, err_next;
  logic                    sx_neg_reg, sx_neg_next, sy_neg_reg, sy_neg_next;
  logic                    wr_ena_reg, wr_ena_next;
  logic [AW-1:0]           wr_addr_reg, wr_addr_next;
  logic [VRAM_W-1:0]       wr_data_reg, wr_data_next;

  logic signed [DW-1:0]    x0_s, x1_s, y0_s, y1_s, adx, ady;
  logic signed [DW:0]      e2, dx_w, dy_w;
  logic [31:0]             pix_lin;
  logic                    touch_in_range, touch_is_last;

  assign x0_s = signed'(DW'(x_reg));
  assign x1_s = signed'(DW'(x1_reg));
  assign y0_s = signed'(DW'(y_reg));
  assign y1_s = signed'(DW'(y1_reg));
  assign e2   = {err_reg, 1'b0};
  assign dx_w = (DW + 1)'(dx_reg);
  assign dy_w = (DW + 1)'(dy_reg);

  // Linear address of the current pixel; the multiply is by a constant.
  assign pix_lin = 32'(y_reg) * WIDTH_U + 32'(x_reg);

  assign touch_in_range = ({1'b0, touch_x} < X_LIM) && ({1'b0, touch_y} < Y_LIM);
  assign touch_is_last  = pen_down_reg && (touch_x == x1_reg) && (touch_y == y1_reg);

  assign busy         = (state_reg != S_IDLE);
  assign vram_wr_ena  = wr_ena_reg;
  assign vram_wr_addr = wr_addr_reg;
  assign vram_wr_data = wr_data_reg;

  // Next-state, datapath and write-port logic for the clear/idle/setup/draw FSM.
  always_comb begin
    state_next         = state_reg;
    clr_cnt_next       = clr_cnt_reg;
    pen_down_next      = pen_down_reg;
    pending_clear_next = pending_clear_reg | (clear_req & (state_reg != S_IDLE));
    x_next             = x_reg;
    y_next             = y_reg;
    x1_next            = x1_reg;
    y1_next            = y1_reg;
    color_next         = color_reg;
    dx_next            = dx_reg;
    dy_next            = dy_reg;
    err_next           = err_reg;
    sx_neg_next        = sx_neg_reg;
    sy_neg_next        = sy_neg_reg;
    wr_ena_next        = 1'b0;
    wr_addr_next       = wr_addr_reg;
    wr_data_next       = wr_data_reg;
    adx                = (x1_s > x0_s) ? (x1_s - x0_s) : (x0_s - x1_s);
    ady                = (y1_s > y0_s) ? (y1_s - y0_s) : (y0_s - y1_s);

    case (state_reg)
      S_CLEAR: begin
        wr_ena_next  = 1'b1;
        wr_addr_next = clr_cnt_reg;
        wr_data_next = BACKGROUND;
        if (clr_cnt_reg == '0) begin
          state_next    = S_IDLE;
          pen_down_next = 1'b0;
          clr_cnt_next  = CLR_TOP;
        end else begin
          clr_cnt_next = clr_cnt_reg - AW'(1);
        end
      end

      S_IDLE: begin
        if (pending_clear_reg || clear_req) begin
          state_next         = S_CLEAR;
          pending_clear_next = 1'b0;
        end else if (!touch_valid) begin
          pen_down_next = 1'b0;
        end else if (touch_in_range && !touch_is_last) begin
          x1_next    = touch_x;
          y1_next    = touch_y;
          color_next = draw_color;
          // A fresh pen-down starts a single-pixel segment at the new point.
          x_next     = pen_down_reg ? x1_reg : touch_x;
          y_next     = pen_down_reg ? y1_reg : touch_y;
          state_next = S_SETUP;
        end
      end

      S_SETUP: begin
        dx_next     = adx;
        dy_next     = -ady;
        err_next    = adx - ady;
        sx_neg_next = !(x0_s < x1_s);
        sy_neg_next = !(y0_s < y1_s);
        state_next  = S_DRAW;
      end

      S_DRAW: begin
        wr_ena_next  = 1'b1;
        wr_addr_next = AW'(pix_lin);
        wr_data_next = color_reg;
        if ((x_reg == x1_reg) && (y_reg == y1_reg)) begin
          pen_down_next = 1'b1;
          state_next    = S_IDLE;
        end else begin
          if (e2 >= dy_w) begin
            err_next = err_next + dy_reg;
            x_next   = sx_neg_reg ? (x_reg - XW'(1)) : (x_reg + XW'(1));
          end
          if (e2 <= dx_w) begin
            err_next = err_next + dx_reg;
            y_next   = sy_neg_reg ? (y_reg - YW'(1)) : (y_reg + YW'(1));
          end
        end
      end

      default: state_next = S_CLEAR;
    endcase
  end

  // State and output registers; reset restarts the full clear from the top.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_CLEAR;
      clr_cnt_reg       <= CLR_TOP;
      pen_down_reg      <= 1'b0;
      pending_clear_reg <= 1'b0;
      x_reg             <= '0;
      y_reg             <= '0;
      x1_reg            <= '0;
      y1_reg            <= '0;
      color_reg         <= '0;
      dx_reg            <= '0;
      dy_reg            <= '0;
      err_reg           <= '0;
      sx_neg_reg        <= 1'b0;
      sy_neg_reg        <= 1'b0;
      wr_ena_reg        <= 1'b0;
      wr_addr_reg       <= '0;
      wr_data_reg       <= '0;
    end else begin
      state_reg         <= state_next;
      clr_cnt_reg       <= clr_cnt_next;
      pen_down_reg      <= pen_down_next;
      pending_clear_reg <= pending_clear_next;
      x_reg             <= x_next;
      y_reg             <= y_next;
      x1_reg            <= x1_next;
      y1_reg            <= y1_next;
      color_reg         <= color_next;
      dx_reg            <= dx_next;
      dy_reg            <= dy_next;
      err_reg           <= err_next;
      sx_neg_reg        <= sx_neg_next;
      sy_neg_reg        <= sy_neg_next;
      wr_ena_reg        <= wr_ena_next;
      wr_addr_reg       <= wr_addr_next;
      wr_data_reg       <= wr_data_next;
    end
  end

endmodule

// File: tb/tb_touch_stroke_rasterizer.sv
// Testbench for touch_stroke_rasterizer.
// Width is kept at 240 so row addresses match the reference points; height is
// reduced to 60 rows so each full clear stays short (14400 writes).
module tb_touch_stroke_rasterizer;

  localparam int W    = 240;
  localparam int H    = 60;
  localparam int L    = W * H;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int AW   = $clog2(L);
  localparam int HOLD = 260;   // longer than the longest segment plus latency

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          touch_valid = 1'b0;
  logic [XW-1:0] touch_x = '0;
  logic [YW-1:0] touch_y = '0;
  logic [15:0]   draw_color = '0;
  logic          clear_req = 1'b0;
  logic          vram_wr_ena;
  logic [AW-1:0] vram_wr_addr;
  logic [15:0]   vram_wr_data;
  logic          busy;

  always #5 clk = ~clk;

  touch_stroke_rasterizer #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .draw_color  (draw_color),
    .clear_req   (clear_req),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .busy        (busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Captured writes and expected writes, each packed as {addr, data}.
  logic [AW+15:0] got_q[$];
  logic [AW+15:0] exp_q[$];
  bit             cap_en = 1'b0;

  always @(negedge clk) begin
    if (cap_en && vram_wr_ena) got_q.push_back({vram_wr_addr, vram_wr_data});
  end

  function automatic int addr_of(input logic [AW+15:0] e);
    return int'(e[AW+15:16]);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: pen state plus a textbook integer line walk.
  bit m_pen = 1'b0;
  int m_lx  = 0;
  int m_ly  = 0;

  task automatic model_line(input int x0, input int y0, input int x1, input int y1,
                            input logic [15:0] c);
    int dx, dy, sx, sy, err, e2, x, y;
    dx = iabs(x1 - x0);
    dy = -iabs(y1 - y0);
    sx = (x0 < x1) ? 1 : -1;
    sy = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x = x0;
    y = y0;
    for (int guard = 0; guard < 1000; guard++) begin
      exp_q.push_back({AW'(y * W + x), c});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // Present one touch sample, hold it, and compare all resulting writes.
  task automatic apply_sample(input logic v, input int x, input int y, input logic [15:0] c);
    int  exp_len;
    int  bad;
    bit  acc;
    exp_len = 0;
    acc     = 1'b0;
    exp_q.delete();
    if (!v) begin
      m_pen = 1'b0;
    end else if (x >= W || y >= H) begin
      acc = 1'b0;
    end else if (m_pen && x == m_lx && y == m_ly) begin
      acc = 1'b0;
    end else begin
      model_line(m_pen ? m_lx : x, m_pen ? m_ly : y, x, y, c);
      exp_len = m_pen ? (((iabs(x - m_lx) > iabs(y - m_ly)) ? iabs(x - m_lx) : iabs(y - m_ly)) + 1) : 1;
      acc   = 1'b1;
      m_pen = 1'b1;
      m_lx  = x;
      m_ly  = y;
    end
    @(negedge clk);
    touch_valid = v;
    touch_x     = x[XW-1:0];
    touch_y     = y[YW-1:0];
    draw_color  = c;
    got_q.delete();
    cap_en = 1'b1;
    repeat (HOLD) @(negedge clk);
    cap_en = 1'b0;
    check("seg_write_count", got_q.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
    check("seg_first_bad_index", bad, -1);
    if (bad >= 0)
      $display("  write %0d differs: got addr=%0d data=%h, want addr=%0d data=%h", bad,
               addr_of(got_q[bad]), got_q[bad][15:0], addr_of(exp_q[bad]), exp_q[bad][15:0]);
    if (acc) check("seg_len_rule", got_q.size(), exp_len);
    $display("sample valid=%0d (%0d,%0d) color=%h -> %0d writes", v, x, y, c, got_q.size());
  endtask

  // Full clear: consecutive writes L-1 down to 0 of background, then idle.
  task automatic check_clear(input string tag);
    int waited, bad, first_bad;
    waited = 0;
    bad = 0;
    first_bad = -1;
    @(negedge clk);
    while (!vram_wr_ena && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_clear_started"}, vram_wr_ena, 1);
    if (vram_wr_ena) begin
      for (int i = 0; i < L; i++) begin
        if (i > 0) @(negedge clk);
        if (!(vram_wr_ena === 1'b1 && vram_wr_addr == AW'(L - 1 - i) && vram_wr_data == 16'h0000)) begin
          if (bad == 0) first_bad = i;
          bad++;
        end
      end
      check({tag, "_clear_bad_writes"}, bad, 0);
      if (bad > 0) $display("  first bad clear write index %0d", first_bad);
      check({tag, "_busy_after_clear"}, busy, 0);
      @(negedge clk);
      check({tag, "_ena_after_clear"}, vram_wr_ena, 0);
      $display("clear %s: %0d writes checked, %0d bad", tag, L, bad);
    end
  endtask

  typedef struct packed {
    logic        v;
    int          x;
    int          y;
    logic [15:0] c;
    int          n;
    int          fa;
    int          la;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bad, waited, r, x, y;
    logic v;

    vecs[0] = '{1'b1, 10,  20, 16'hFFFF, 1,   4810,  4810};
    vecs[1] = '{1'b1, 10,  20, 16'hFFFF, 0,   0,     0};
    vecs[2] = '{1'b1, 14,  22, 16'hFFFF, 5,   4810,  5294};
    vecs[3] = '{1'b0, 14,  22, 16'hFFFF, 0,   0,     0};
    vecs[4] = '{1'b1, 50,  50, 16'h1234, 1,   12050, 12050};
    vecs[5] = '{1'b1, 240, 5,  16'h1234, 0,   0,     0};
    vecs[6] = '{1'b1, 5,   60, 16'h1234, 0,   0,     0};
    vecs[7] = '{1'b1, 239, 59, 16'hABCD, 190, 12050, 14399};
    vecs[8] = '{1'b1, 0,   0,  16'h0F0F, 240, 14399, 0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ena", vram_wr_ena, 0);
    check("rst_addr", vram_wr_addr, 0);
    check("rst_data", vram_wr_data, 0);
    check("rst_busy", busy, 1);
    rst = 1'b0;
    check_clear("power_on");

    // Table-driven touch samples.
    for (int i = 0; i < 9; i++) begin
      apply_sample(vecs[i].v, vecs[i].x, vecs[i].y, vecs[i].c);
      check("vec_count", got_q.size(), vecs[i].n);
      if (vecs[i].n > 0 && got_q.size() > 0) begin
        check("vec_first_addr", addr_of(got_q[0]), vecs[i].fa);
        check("vec_last_addr", addr_of(got_q[got_q.size() - 1]), vecs[i].la);
        bad = 0;
        foreach (got_q[k]) if (got_q[k][15:0] != vecs[i].c) bad++;
        check("vec_color", bad, 0);
      end
    end

    // Segment (0,0)->(0,9) with a clear request on the first DRAW cycle.
    @(negedge clk);
    touch_y = 6'd9;
    draw_color = 16'h00FF;
    @(negedge clk);
    check("lat_cycle1_ena", vram_wr_ena, 0);
    @(negedge clk);
    check("lat_cycle2_ena", vram_wr_ena, 0);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    check("lat_cycle3_ena", vram_wr_ena, 1);
    check("lat_cycle3_addr", vram_wr_addr, 0);
    bad = 0;
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (!(vram_wr_ena === 1'b1 && vram_wr_addr == AW'(k * W) && vram_wr_data == 16'h00FF)) bad++;
    end
    check("creq_line_pixels", bad, 0);
    $display("segment (0,0)->(0,9) with clear_req: 10 pixels, %0d bad", bad);
    check_clear("clear_req");

    // Clear dropped pen-down, so the still-held (0,9) is redrawn as one pixel.
    waited = 0;
    while (!vram_wr_ena && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    check("post_clear_tap_ena", vram_wr_ena, 1);
    check("post_clear_tap_addr", vram_wr_addr, 9 * W);
    @(negedge clk);
    check("post_clear_tap_single", vram_wr_ena, 0);
    $display("held (0,9) after clear -> addr %0d", 9 * W);

    // Reset on the third pixel of (0,9)->(20,9).
    touch_x = 8'd20;
    repeat (5) @(negedge clk);
    check("rst_mid_pix3_ena", vram_wr_ena, 1);
    check("rst_mid_pix3_addr", vram_wr_addr, 9 * W + 2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_ena", vram_wr_ena, 0);
    check("rst_mid_addr", vram_wr_addr, 0);
    check("rst_mid_data", vram_wr_data, 0);
    check("rst_mid_busy", busy, 1);
    rst = 1'b0;
    touch_valid = 1'b0;
    check_clear("mid_line_reset");
    m_pen = 1'b0;

    // Randomized samples against the reference model.
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      v = 1'b1;
      x = $urandom_range(0, W - 1);
      y = $urandom_range(0, H - 1);
      if (r == 0) v = 1'b0;
      else if (r == 1) begin
        if ($urandom_range(0, 1) == 0) x = $urandom_range(W, 255);
        else y = $urandom_range(H, 63);
      end else if (r == 2) begin
        x = m_lx;
        y = m_ly;
      end else if (r == 3) begin
        x = (m_lx + $urandom_range(0, 6) > W - 1) ? W - 1 : m_lx + $urandom_range(0, 6);
        y = (m_ly >= 3) ? m_ly - $urandom_range(0, 3) : m_ly;
      end
      apply_sample(v, x, y, 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
